aes_enc_key_stream: RTL
=======================

// Module: aes_enc_key_stream
// PURPOSE
//  Forward AES-128 key schedule for the encryption datapath: loads a 128-bit cipher key and
//  streams round keys 0..10 in ascending order over a valid/ready handshake, one per cycle
//  at full throughput. No 11-entry key array: one key register is advanced on each accepted beat.
//  Also latches round key 10 as the decryption start key (dec_key) for the inverse-order side.
// PARAMETERS
//  NR     10   number of rounds; round keys 0..NR are streamed (only 10 supported)
//  KEY_W  128  key width in bits (only 128 supported)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  key_load   in   1      load request; accepted only when key_ready=1
//  key_in     in   KEY_W  cipher key; sampled on the accepting edge
//  key_ready  out  1      1 in IDLE (load can be accepted)
//  rk_valid   out  1      rk_data/rk_round hold a valid round key
//  rk_ready   in   1      consumer accepts the current round key
//  rk_data    out  KEY_W  round key, registered
//  rk_round   out  4      index of rk_data, 0..NR
//  done       out  1      one-cycle pulse after round key NR is accepted
//  dec_key    out  KEY_W  round key NR of the last completed schedule; holds until next completion
// BEHAVIOUR
//  - Reset (async assert, any state): state=IDLE, key_ready=1, rk_valid=0, rk_data=0,
//    rk_round=0, done=0, dec_key=0. Reset mid-stream drops the stream; no done pulse.
//  - FSM: IDLE, STREAM.
//    IDLE: key_load=1 -> rk_data<=key_in, rk_round<=0, rk_valid<=1, key_ready<=0, go STREAM.
//    STREAM: rk_valid=1 throughout; key_load ignored (key_ready=0).
//      rk_valid&rk_ready & rk_round<NR -> rk_data<=expand(rk_data,rcon[rk_round+1]),
//        rk_round<=rk_round+1; rk_valid stays 1 (no bubble).
//      rk_valid&rk_ready & rk_round==NR -> dec_key<=rk_data, done<=1 for one cycle,
//        rk_valid<=0, key_ready<=1, go IDLE. rk_data/rk_round keep their last value.
//      rk_ready=0 -> rk_data, rk_round, rk_valid stable (backpressure, any duration).
//  - Latency: load accepted at edge t -> key 0 valid after t; key i valid at earliest after
//    edge t+i; 11 handshake cycles minimum per schedule. done asserts after the edge accepting key NR.
//  - Back-to-back: key_load may be accepted in the same cycle done=1 (key_ready=1 then).
//  - expand(k,rc), words w0..w3 = k[127:96]..k[31:0]:
//    t=SubWord(RotWord(w3)) ^ {rc,24'h0}; n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
//    RotWord {a,b,c,d}->{b,c,d,a}; SubWord = forward AES S-box per byte; all XOR, no carries.
//  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; index 0 / 11..15 unused (return 00).
//  - expand is combinational from the rk_data register; its output is registered on the beat.
// STRUCTURE
//  - Shared package aes_pkg: KEY_W, NR, state enum {IDLE,STREAM}, rcon table function,
//    forward S-box function (also used by the encryption round).
//  - One sub-module: aes_key_expand_round (in: prev_key[127:0], rcon[7:0]; out: next_key[127:0]),
//    purely combinational, 4 S-box lookups.
//  - Top: FSM, rk_data/rk_round/dec_key registers, done pulse register.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round 0 = key_in, round 1 =
//    a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6,
//    11 consecutive valid cycles, done one cycle later, dec_key = round-10 value.
//  2 Same key, rk_ready toggling pseudo-randomly (incl. 5-cycle stall at round 4) ->
//    rk_data/rk_round stable while stalled, sequence identical to scenario 1.
//  3 key_load=1 with key 000..0 while STREAM at round 3 -> ignored, stream of first key completes;
//    then all-zero key -> round 1 = 62636363626363636263636362636363.
//  4 rst_n low for 1 cycle at round 6 -> all outputs 0 immediately, key_ready=1, no done;
//    fresh load afterward restarts at round 0.
//  5 key_load held high across done -> second schedule accepted in done cycle, key 0 valid
//    next cycle, dec_key updated only at second completion.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type, round-constant table and forward S-box.
// Latency: n/a (package of types and pure combinational functions).
// Backpressure: n/a.
// Contents: AES_KEY_W, AES_NR, ks_state_t {IDLE, STREAM}, aes_rcon(), aes_sbox().
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_NR    = 10;

  typedef enum logic {
    IDLE,
    STREAM
  } ks_state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for round idx (1..10); unused indices give 00.
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Entry b sits at bit offset (255-b)*8; for an 8-bit b that is {~b, 3'b000}.
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [10:0] ofs;
    ofs = {~b, 3'b000};
    return AES_SBOX[ofs +: 8];
  endfunction

endpackage

// File: rtl/aes_key_expand_round.sv
// One step of the AES-128 forward key expansion: next round key from the previous one.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: prev_key (round key i), rcon (constant for round i+1), next_key (round key i+1).
module aes_key_expand_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] prev_key,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // SubWord(RotWord(w3)): rotate left by one byte, then substitute each byte.
  assign t = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]),
              aes_sbox(w3[7:0]),   aes_sbox(w3[31:24])} ^ {rcon, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc_key_stream.sv
// Streams AES-128 round keys 0..NR from one advancing register; latches key NR as dec_key.
// Latency: key 0 valid the cycle after load; one key per accepted beat, done pulses after key NR.
// Backpressure: rk_ready=0 holds rk_data/rk_round/rk_valid for any duration; key_load only taken in IDLE.
// Ports: clk, rst_n; key_load/key_in/key_ready (load side); rk_valid/rk_ready/rk_data/rk_round
//        (round-key stream); done (completion pulse); dec_key (last round key of last schedule).
module aes_enc_key_stream
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_ready,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             done,
  output logic [KEY_W-1:0] dec_key
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_t        state;
  logic [KEY_W-1:0] next_key;

  // Expansion runs off the registered key; the result is only captured on a handshake.
  aes_key_expand_round u_expand (
    .prev_key (rk_data),
    .rcon     (aes_rcon(rk_round + 4'd1)),
    .next_key (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_round  <= '0;
      done      <= 1'b0;
      dec_key   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_load) begin
            rk_data   <= key_in;
            rk_round  <= '0;
            rk_valid  <= 1'b1;
            key_ready <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (rk_valid && rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              // rk_data/rk_round are left holding the final key.
              dec_key   <= rk_data;
              done      <= 1'b1;
              rk_valid  <= 1'b0;
              key_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              rk_data  <= next_key;
              rk_round <= rk_round + 4'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          rk_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
